// File: rtl/trig_burst_capture_if.sv
// Captured-sample output stream (valid/ready) for trig_burst_capture.
// Carries a per-word timestamp when TBC_TSTAMP_EN is defined.
interface trig_burst_capture_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
`ifdef TBC_TSTAMP_EN
  logic [31:0]       m_tstamp;

  modport master (output m_data, m_valid, m_tstamp, input m_ready);
  modport slave  (input m_data, m_valid, m_tstamp, output m_ready);
`else
  modport master (output m_data, m_valid, input m_ready);
  modport slave  (input m_data, m_valid, output m_ready);
`endif
endinterface

// File: rtl/trig_burst_capture.sv
// Trigger-armed burst capture into a FIFO with a registered valid/ready output.
// Optional TBC_TSTAMP_EN tags each word with the cycle count at its trigger.
module trig_burst_capture #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trigger,
  input  logic                 arm,
  input  logic                 cont,
  input  logic [15:0]          burst_len,
  input  logic [DATA_W-1:0]    din,
  input  logic                 din_valid,
  trig_burst_capture_if.master m,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
`ifdef TBC_TSTAMP_EN
  localparam int WW = DATA_W + 32;
`else
  localparam int WW = DATA_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_e;

  state_e          state_q, state_d;
  logic [15:0]     rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_after_pop;
  logic [CW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WW-1:0]   head_q, head_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic            push, pop;
  logic [WW-1:0]   wr_word;
  logic [WW-1:0]   mem_q [DEPTH];

`ifdef TBC_TSTAMP_EN
  logic [31:0] ts_cnt_q, ts_cnt_d, ts_burst_q, ts_burst_d;
  assign wr_word    = {ts_burst_q, din};
  assign m.m_tstamp = head_q[WW-1:DATA_W];
`else
  assign wr_word = din;
`endif

  assign m.m_data  = head_q[DATA_W-1:0];
  assign m.m_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    push    = 1'b0;
    pop     = valid_q && m.m_ready;
`ifdef TBC_TSTAMP_EN
    ts_cnt_d   = ts_cnt_q + 32'd1;
    ts_burst_d = ts_burst_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_ARMED;
          ovf_d   = 1'b0;
        end
      end
      S_ARMED: begin
        if (trigger) begin
          state_d = S_CAPTURE;
          rem_d   = (burst_len == 16'd0) ? 16'd1 : burst_len;
`ifdef TBC_TSTAMP_EN
          ts_burst_d = ts_cnt_q;
`endif
        end
      end
      S_CAPTURE: begin
        if (din_valid) begin
          // A full FIFO drops the sample but it still counts toward the burst.
          if (cnt_q < DEPTH_C) push = 1'b1;
          else                 ovf_d = 1'b1;
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = cont ? S_ARMED : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d        = (state_d != S_IDLE);
    wr_ptr_d      = wr_ptr_q + CW'(push);
    rd_ptr_d      = rd_ptr_q + CW'(pop);
    cnt_after_pop = cnt_q - CW'(pop);
    cnt_d         = cnt_after_pop + CW'(push);
    valid_d       = (cnt_d != '0);

    // Output register mirrors the FIFO head; an empty FIFO takes the new word directly.
    head_d = head_q;
    if (cnt_after_pop == '0) begin
      if (push) head_d = wr_word;
    end else begin
      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  // NOTE: sample storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  // NOTE: state uses non-blocking assignments with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef TBC_TSTAMP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt_q   <= '0;
      ts_burst_q <= '0;
    end else begin
      ts_cnt_q   <= ts_cnt_d;
      ts_burst_q <= ts_burst_d;
    end
  end
`endif

endmodule

// File: tb/tb_trig_burst_capture.sv
// Randomized scoreboard bench for trig_burst_capture with a behavioural reference model.
// Model runs on the rising edge, the monitor compares on the falling edge.
module tb_trig_burst_capture;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;

  typedef struct {
    logic [15:0] d;
    logic [31:0] ts;
  } word_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              trigger = 1'b0;
  logic              arm = 1'b0;
  logic              cont = 1'b0;
  logic [15:0]       burst_len = '0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              m_ready = 1'b0;
  logic              busy, done, overflow;

  trig_burst_capture_if #(.DATA_W(DATA_W)) sif ();
  assign sif.m_ready = m_ready;

  trig_burst_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trigger   (trigger),
    .arm       (arm),
    .cont      (cont),
    .burst_len (burst_len),
    .din       (din),
    .din_valid (din_valid),
    .m         (sif),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model state
  bit          armed_m = 0, cap_m = 0, done_m = 0, ovf_m = 0, busy_m = 0;
  int          left_m = 0, occ_m = 0;
  logic [31:0] cyc_m = '0, ts_m = '0;
  word_t       exp_q[$];

  // Observation logs for directed checks
  logic [15:0] seen_q[$];
  logic [31:0] seen_ts_q[$];
  int          done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit    push, pop;
    word_t w;
    if (!rst_n) begin
      armed_m = 0; cap_m = 0; done_m = 0; ovf_m = 0;
      left_m = 0; occ_m = 0; cyc_m = '0; ts_m = '0;
      exp_q.delete();
    end else begin
      pop    = (occ_m > 0) && m_ready;
      push   = 0;
      done_m = 0;
      if (cap_m) begin
        if (din_valid) begin
          if (occ_m < DEPTH) begin
            push = 1;
            w.d  = din;
            w.ts = ts_m;
            exp_q.push_back(w);
          end else begin
            ovf_m = 1;
          end
          left_m--;
          if (left_m == 0) begin
            done_m  = 1;
            cap_m   = 0;
            armed_m = cont;
          end
        end
      end else if (armed_m) begin
        if (trigger) begin
          armed_m = 0;
          cap_m   = 1;
          left_m  = (burst_len == 16'd0) ? 1 : int'(burst_len);
          ts_m    = cyc_m;
        end
      end else if (arm) begin
        armed_m = 1;
        ovf_m   = 0;
      end
      occ_m = occ_m + int'(push) - int'(pop);
      cyc_m = cyc_m + 32'd1;
    end
    busy_m = armed_m || cap_m;
  endtask

  task automatic monitor_step();
    word_t w;
    check("m_valid", sif.m_valid, 32'(occ_m > 0));
    check("busy", busy, 32'(busy_m));
    check("done", done, 32'(done_m));
    check("overflow", overflow, 32'(ovf_m));
    if (done) done_cnt++;
    if (sif.m_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_data: got 0x%0h, expected no word (t=%0t)", sif.m_data, $time);
      end else begin
        w = exp_q[0];
        check("m_data", sif.m_data, 32'(w.d));
`ifdef TBC_TSTAMP_EN
        check("m_tstamp", sif.m_tstamp, w.ts);
`endif
        if (m_ready) begin
          void'(exp_q.pop_front());
          seen_q.push_back(sif.m_data);
`ifdef TBC_TSTAMP_EN
          seen_ts_q.push_back(sif.m_tstamp);
`endif
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) monitor_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    trigger = 0; arm = 0; din_valid = 0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    seen_q.delete();
    seen_ts_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic drain();
    m_ready = 1'b1;
    din_valid = 1'b0;
    repeat (DEPTH + 4) tick();
  endtask

  initial begin
    int busy_low;

    // Reset values
    rst_n = 1'b0;
    tick();
    mon_en = 1'b1;
    check("rst m_data", sif.m_data, 0);
    check("rst m_valid", sif.m_valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst overflow", overflow, 0);
`ifdef TBC_TSTAMP_EN
    check("rst m_tstamp", sif.m_tstamp, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Single shot, ramp data; the trigger-cycle sample is excluded
    clear_logs();
    cont = 0; burst_len = 16'd4; m_ready = 1; din_valid = 1; din = 16'h0f;
    pulse_arm();
    for (int i = 0; i < 8; i++) begin
      din = 16'h10 + 16'(i);
      trigger = (i == 0);
      tick();
    end
    trigger = 0;
    wait_idle(20, "single busy");
    drain();
    check("single words", seen_q.size(), 4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++)
      check("single seq", seen_q[i], 32'h11 + 32'(i));
    check("single done", done_cnt, 1);

    // burst_len = 0 behaves as 1
    clear_logs();
    burst_len = 16'd0;
    pulse_arm();
    trigger = 1; din = $urandom; din_valid = 1;
    tick();
    trigger = 0;
    for (int i = 0; i < 6; i++) begin
      din = $urandom;
      din_valid = $urandom_range(0, 1);
      tick();
    end
    wait_idle(30, "len0 busy");
    drain();
    check("len0 words", seen_q.size(), 1);
    check("len0 done", done_cnt, 1);

    // Overflow: 20 samples into a 16-deep FIFO with no readout
    clear_logs();
    do_reset();
    burst_len = 16'd20; m_ready = 0; din_valid = 1;
    pulse_arm();
    trigger = 1;
    tick();
    trigger = 0;
    for (int i = 0; i < 24; i++) begin
      din = $urandom;
      tick();
    end
    check("ovf flag", overflow, 1);
    check("ovf done", done_cnt, 1);
    drain();
    check("ovf stored", seen_q.size(), DEPTH);
    check("ovf held", overflow, 1);
    pulse_arm();
    check("ovf cleared", overflow, 0);

    // Continuous mode with extra triggers landing during capture
    clear_logs();
    do_reset();
    cont = 1; burst_len = 16'd3;
    pulse_arm();
    busy_low = 0;
    for (int i = 0; i < 60; i++) begin
      trigger   = (i % 10 == 0) || (i % 10 == 2);
      din       = $urandom;
      din_valid = ($urandom_range(0, 3) != 0);
      m_ready   = $urandom_range(0, 1);
      tick();
      if (!busy) busy_low++;
    end
    trigger = 0; din_valid = 1;
    repeat (6) tick();
    check("cont busy held", busy_low, 0);
    drain();
    check("cont words", seen_q.size(), 3 * done_cnt);
    check("cont bursts", 32'(done_cnt >= 4), 1);

    // Reset mid-burst
    clear_logs();
    do_reset();
    cont = 0; burst_len = 16'd8; m_ready = 0;
    pulse_arm();
    trigger = 1; din_valid = 1;
    tick();
    trigger = 0;
    repeat (2) begin
      din = $urandom;
      tick();
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    check("midrst m_valid", sif.m_valid, 0);
    check("midrst busy", busy, 0);
    trigger = 1; m_ready = 1;
    tick();
    trigger = 0;
    repeat (10) tick();
    din_valid = 0;
    check("midrst ignore trig", busy, 0);
    check("midrst no done", done_cnt, 0);
    check("midrst no words", seen_q.size(), 0);

`ifdef TBC_TSTAMP_EN
    // Timestamp: trigger accepted at counter value 100
    clear_logs();
    do_reset();
    burst_len = 16'd3; m_ready = 1; din_valid = 0;
    pulse_arm();
    for (int n = 0; n < 200 && cyc_m != 32'd100; n++) tick();
    check("ts align", cyc_m, 100);
    trigger = 1;
    tick();
    trigger = 0; din_valid = 1;
    repeat (3) begin
      din = $urandom;
      tick();
    end
    din_valid = 0;
    drain();
    check("ts words", seen_ts_q.size(), 3);
    foreach (seen_ts_q[i]) check("ts value", seen_ts_q[i], 100);
`endif

    // Randomized soak
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      arm       = ($urandom_range(0, 7) == 0);
      trigger   = ($urandom_range(0, 5) == 0);
      if (i % 50 == 0) cont = $urandom_range(0, 1);
      burst_len = ($urandom_range(0, 9) == 0) ? 16'd20 : 16'($urandom_range(0, 6));
      din       = $urandom;
      din_valid = $urandom_range(0, 1);
      m_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end
    arm = 0; trigger = 0; rst_n = 1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
